// File: rtl/seq_muldiv_pkg.sv
// seq_muldiv_pkg: op encoding, FSM states and latency helper
// shared by the sequential multiply/divide unit and its bench.
package seq_muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // start-accept edge to done: W iterations + FIX + DONE
  function automatic int latency(input int w);
    return w + 2;
  endfunction

endpackage

// File: rtl/seq_muldiv_addsub.sv
// seq_muldiv_addsub: W+1-bit adder/subtractor with carry out.
// Ports: x_i, y_i operands; sub_i selects x-y; sum_o, cout_o.
module seq_muldiv_addsub #(
  parameter int W = 16
) (
  input  logic [W:0] x_i,
  input  logic [W:0] y_i,
  input  logic       sub_i,
  output logic [W:0] sum_o,
  output logic       cout_o
);

  logic [W:0]   y_eff;
  logic [W+1:0] full;

  assign y_eff = sub_i ? ~y_i : y_i;

  // on subtract, cout_o = 1 means x_i >= y_i (no borrow)
  assign full = {1'b0, x_i}
              + {1'b0, y_eff}
              + {{(W+1){1'b0}}, sub_i};

  assign sum_o  = full[W:0];
  assign cout_o = full[W+1];

endmodule

// File: rtl/seq_muldiv.sv
// seq_muldiv: iterative shift-add multiply / restoring divide.
// Ports: clk, rst (sync, high), start, op[1:0], a, b, wr_hi,
//   wr_lo in; busy, done, dz, hi, lo out.
// Macro SEQ_MULDIV_SIGNED_EN enables signed MULT/DIV.
module seq_muldiv
  import seq_muldiv_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         wr_hi,
  input  logic         wr_lo,
  output logic         busy,
  output logic         done,
  output logic         dz,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int NITER = latency(W) - 2;
  localparam int CW    = $clog2(NITER);

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  mq_q, mq_d;
  logic [W-1:0]  opnd_q, opnd_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic          is_div_q, is_div_d;
  logic          dzp_q, dzp_d;
  logic          dz_q, dz_d;

  op_e          op_in;
  logic         is_div_in;
  logic [W-1:0] mag_a;
  logic [W-1:0] mag_b;

  assign op_in     = op_e'(op);
  assign is_div_in = op_in inside {OP_DIVU, OP_DIV};

`ifdef SEQ_MULDIV_SIGNED_EN
  logic sgn_in;
  logic sa;
  logic sb;
  logic neg_q, neg_d;
  logic rneg_q, rneg_d;
  logic [2*W-1:0] prod;

  assign sgn_in = op_in inside {OP_MULT, OP_DIV};
  assign sa     = sgn_in & a[W-1];
  assign sb     = sgn_in & b[W-1];
  assign mag_a  = sa ? ~a + 1'b1 : a;
  assign mag_b  = sb ? ~b + 1'b1 : b;
  assign prod   = {acc_q, mq_q};
`else
  assign mag_a = a;
  assign mag_b = b;
`endif

  logic [W:0] as_x;
  logic [W:0] as_y;
  logic       as_sub;
  logic [W:0] as_sum;
  logic       as_cout;

  seq_muldiv_addsub #(.W(W)) u_addsub (
    .x_i   (as_x),
    .y_i   (as_y),
    .sub_i (as_sub),
    .sum_o (as_sum),
    .cout_o(as_cout)
  );

  // multiply: acc + multiplicand
  // divide: {rem, next dividend bit} - divisor
  always_comb begin
    as_x   = {1'b0, acc_q};
    as_y   = {1'b0, opnd_q};
    as_sub = 1'b0;
    if (is_div_q) begin
      as_x   = {acc_q, mq_q[W-1]};
      as_sub = 1'b1;
    end
  end

  logic [W:0] mstep;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    dzp_d    = dzp_q;
    dz_d     = dz_q;
    mstep    = '0;
`ifdef SEQ_MULDIV_SIGNED_EN
    neg_d    = neg_q;
    rneg_d   = rneg_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_CALC;
          cnt_d    = '0;
          acc_d    = '0;
          mq_d     = mag_a;
          opnd_d   = mag_b;
          is_div_d = is_div_in;
          dzp_d    = is_div_in && (b == '0);
          dz_d     = 1'b0;
`ifdef SEQ_MULDIV_SIGNED_EN
          neg_d    = sa ^ sb;
          rneg_d   = sa;
`endif
        end else begin
          if (wr_hi) hi_d = a;
          if (wr_lo) lo_d = a;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(NITER - 1)) state_d = S_FIX;
        if (is_div_q) begin
          // restoring step: keep difference only if no borrow
          if (as_cout) acc_d = as_sum[W-1:0];
          else acc_d = {acc_q[W-2:0], mq_q[W-1]};
          mq_d = {mq_q[W-2:0], as_cout};
        end else begin
          mstep = mq_q[0] ? as_sum : {1'b0, acc_q};
          acc_d = mstep[W:1];
          mq_d  = {mstep[0], mq_q[W-1:1]};
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        dz_d    = dzp_q;
`ifdef SEQ_MULDIV_SIGNED_EN
        if (is_div_q) begin
          lo_d = neg_q ? ~mq_q + 1'b1 : mq_q;
          hi_d = rneg_q ? ~acc_q + 1'b1 : acc_q;
        end else begin
          {hi_d, lo_d} = neg_q ? ~prod + 1'b1 : prod;
        end
`else
        hi_d = acc_q;
        lo_d = mq_q;
`endif
        // b == 0 leaves |a| in acc, so hi already
        // reads back the original dividend
        if (dzp_q) lo_d = '1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      dzp_q    <= 1'b0;
      dz_q     <= 1'b0;
`ifdef SEQ_MULDIV_SIGNED_EN
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      dzp_q    <= dzp_d;
      dz_q     <= dz_d;
`ifdef SEQ_MULDIV_SIGNED_EN
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
`endif
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_seq_muldiv.sv
// tb_seq_muldiv: table vectors, random ops vs arithmetic model,
// and hand sequences for busy-ignore and mid-op reset.
module tb_seq_muldiv;
  import seq_muldiv_pkg::*;

  localparam int W   = 16;
  localparam int LAT = latency(W);

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         wr_hi;
  logic         wr_lo;
  logic         busy;
  logic         done;
  logic         dz;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks   = 0;
  int failures = 0;

  seq_muldiv #(.W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .wr_hi(wr_hi),
    .wr_lo(wr_lo),
    .busy (busy),
    .done (done),
    .dz   (dz),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] o,
                     input logic [W-1:0] x, y, h, l,
                     input logic d);
    vec_t v;
    v.op = o; v.a = x; v.b = y;
    v.hi = h; v.lo = l; v.dz = d;
    tbl.push_back(v);
  endtask

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Reference: plain integer arithmetic on the operands
  task automatic model(input logic [1:0] o,
                       input logic [W-1:0] x, y,
                       output logic [W-1:0] eh, el,
                       output logic ed);
    longint sx, sy, p, q, r;
    bit sg;
`ifdef SEQ_MULDIV_SIGNED_EN
    sg = o[0];
`else
    sg = 1'b0;
`endif
    sx = sg ? {{(64-W){x[W-1]}}, x} : {{(64-W){1'b0}}, x};
    sy = sg ? {{(64-W){y[W-1]}}, y} : {{(64-W){1'b0}}, y};
    ed = 1'b0;
    if (!o[1]) begin
      p = sx * sy;
      {eh, el} = p[2*W-1:0];
    end else if (y == '0) begin
      ed = 1'b1;
      el = '1;
      eh = x;
    end else begin
      q = sx / sy;
      r = sx % sy;
      el = q[W-1:0];
      eh = r[W-1:0];
    end
  endtask

  // Issue one op; scramble inputs (incl. start/wr) while busy.
  task automatic run_op(input logic [1:0] o,
                        input logic [W-1:0] x, y,
                        input logic [1:0] wr0,
                        output logic [W-1:0] rh, rl,
                        output logic rdz,
                        output int lat,
                        output bit leak);
    logic [W-1:0] h0, l0;
    h0 = hi;
    l0 = lo;
    op = o; a = x; b = y;
    {wr_hi, wr_lo} = wr0;
    start = 1'b1;
    @(posedge clk);
    lat  = -1;
    leak = 1'b0;
    rh = 'x; rl = 'x; rdz = 1'bx;
    for (int k = 1; k <= LAT + 6; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        rh = hi; rl = lo; rdz = dz;
        break;
      end
      if (hi !== h0 || lo !== l0 || busy !== 1'b1) leak = 1'b1;
      start = 1'($urandom);
      wr_hi = 1'($urandom);
      wr_lo = 1'($urandom);
      op    = 2'($urandom);
      a     = W'($urandom);
      b     = W'($urandom);
    end
    start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    if (lat < 0) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
    @(negedge clk);
  endtask

  logic [W-1:0] rh, rl, eh, el, x, y;
  logic [1:0]   o;
  logic         rdz, edz;
  int           lat, nd, dk;
  bit           leak;

  initial begin
    rst = 1'b1; start = 1'b0;
    wr_hi = 1'b0; wr_lo = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", 64'({busy, done, dz, hi, lo}), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    add(OP_MULTU, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0);
    add(OP_DIVU,  16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1);
    add(OP_DIVU,  16'h0064, 16'h0007, 16'h0002, 16'h000E, 1'b0);
    add(OP_MULTU, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 1'b0);
    add(OP_DIVU,  16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0);
    add(OP_DIVU,  16'h0005, 16'h000A, 16'h0005, 16'h0000, 1'b0);
    add(OP_MULT,  16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0);
    add(OP_DIV,   16'h8000, 16'h0000, 16'h8000, 16'hFFFF, 1'b1);
`ifdef SEQ_MULDIV_SIGNED_EN
    add(OP_MULT,  16'hFFFD, 16'h0007, 16'hFFFF, 16'hFFEB, 1'b0);
    add(OP_DIV,   16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0);
    add(OP_DIV,   16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0);
    add(OP_DIV,   16'h0007, 16'hFFFE, 16'h0001, 16'hFFFD, 1'b0);
    add(OP_DIV,   16'hFFF9, 16'h0000, 16'hFFF9, 16'hFFFF, 1'b1);
`else
    add(OP_MULT,  16'hFFFD, 16'h0007, 16'h0006, 16'hFFEB, 1'b0);
    add(OP_DIV,   16'hFFF9, 16'h0002, 16'h0001, 16'h7FFC, 1'b0);
    add(OP_DIV,   16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0);
    add(OP_DIV,   16'h0007, 16'hFFFE, 16'h0007, 16'h0000, 1'b0);
    add(OP_DIV,   16'hFFF9, 16'h0000, 16'hFFF9, 16'hFFFF, 1'b1);
`endif

    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, 2'b00,
             rh, rl, rdz, lat, leak);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(LAT));
      chk($sformatf("vec%0d_hi", i), 64'(rh), 64'(tbl[i].hi));
      chk($sformatf("vec%0d_lo", i), 64'(rl), 64'(tbl[i].lo));
      chk($sformatf("vec%0d_dz", i), 64'(rdz), 64'(tbl[i].dz));
      chk($sformatf("vec%0d_hold", i), 64'(leak), 64'(0));
    end

    for (int n = 0; n < 60; n++) begin
      o = 2'($urandom_range(0, 3));
      x = W'($urandom);
      y = W'($urandom);
      if ($urandom_range(0, 7) == 0) y = '0;
      if ($urandom_range(0, 7) == 0) x = 16'h8000;
      if ($urandom_range(0, 7) == 0) y = 16'hFFFF;
      model(o, x, y, eh, el, edz);
      run_op(o, x, y, 2'b00, rh, rl, rdz, lat, leak);
      chk($sformatf("rnd%0d_lat", n), 64'(lat), 64'(LAT));
      chk($sformatf("rnd%0d_hi", n), 64'(rh), 64'(eh));
      chk($sformatf("rnd%0d_lo", n), 64'(rl), 64'(el));
      chk($sformatf("rnd%0d_dz", n), 64'(rdz), 64'(edz));
      chk($sformatf("rnd%0d_hold", n), 64'(leak), 64'(0));
    end

    // start and wr_lo pulsed mid-divide must be ignored
    op = OP_DIVU; a = 16'd100; b = 16'd7; start = 1'b1;
    @(posedge clk);
    nd = 0; dk = -1;
    for (int k = 1; k <= LAT + 6; k++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (dk < 0) begin
          dk = k; rh = hi; rl = lo;
        end
      end
      start = (k == 5);
      wr_lo = (k == 5);
      op    = (k == 5) ? OP_MULTU : OP_DIVU;
      a     = (k == 5) ? 16'hABCD : 16'd100;
    end
    chk("busy_start_single_done", 64'(nd), 64'(1));
    chk("busy_start_lat", 64'(dk), 64'(LAT));
    chk("busy_start_lo", 64'(rl), 64'(14));
    chk("busy_start_hi", 64'(rh), 64'(2));

    a = 16'hABCD; wr_lo = 1'b1;
    @(negedge clk);
    wr_lo = 1'b0;
    chk("idle_wr_lo", 64'({hi, lo}), 64'({16'd2, 16'hABCD}));

    a = 16'h5A5A; wr_hi = 1'b1; wr_lo = 1'b1;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;
    chk("idle_wr_both", 64'({hi, lo}), 64'({16'h5A5A, 16'h5A5A}));

    run_op(OP_MULTU, 16'd3, 16'd4, 2'b11, rh, rl, rdz, lat, leak);
    chk("start_wins_hold", 64'(leak), 64'(0));
    chk("start_wins_res", 64'({rh, rl}), 64'({16'd0, 16'd12}));

    // reset in the middle of CALC aborts without done
    op = OP_MULTU; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", 64'({busy, done, dz, hi, lo}), 64'(0));
    nd = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'(0));

    model(OP_MULTU, 16'h1234, 16'h0010, eh, el, edz);
    run_op(OP_MULTU, 16'h1234, 16'h0010, 2'b00,
           rh, rl, rdz, lat, leak);
    chk("after_abort_lat", 64'(lat), 64'(LAT));
    chk("after_abort_res", 64'({rh, rl}), 64'({eh, el}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_muldiv.md
SEQ_MULDIV -- requirements
Module: seq_muldiv

Interface
REQ-001 Parameter W, default 16, operand and result width in bits (W >= 4, even).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  request a new operation; accepted only in IDLE.
REQ-005 op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 a, b  input  W  operands: multiplicand/multiplier or dividend/divisor.
REQ-007 wr_hi, wr_lo  input  1  direct load of HI/LO from `a`; honoured only in IDLE.
REQ-008 busy  output  1  high from the cycle after acceptance until the DONE cycle inclusive.
REQ-009 done  output  1  one-cycle pulse; HI/LO hold the final result in that cycle.
REQ-010 dz  output  1  divide-by-zero flag; valid with done and held until the next acceptance.
REQ-011 hi, lo  output  W  result registers: product high/low half, or remainder/quotient.

Function
REQ-012 States:
- IDLE: wait for start or a direct load.
- CALC: exactly W iterations, one per cycle.
- FIX: one cycle, sign correction.
- DONE: one cycle.
- Transitions: IDLE->CALC on start, then CALC->FIX->DONE->IDLE.
REQ-013 Latency: done SHALL assert exactly W+2 cycles after the start-accept edge, for every op and every operand value.
REQ-014 Multiply SHALL be iterative shift-add; {hi,lo} SHALL equal the full 2W-bit product.
REQ-015 Divide SHALL be iterative restoring division; lo = quotient, hi = remainder.
REQ-016 Signed divide SHALL truncate the quotient toward zero; the remainder SHALL take the sign of the dividend.
REQ-017 Signed ops SHALL take operand magnitudes on acceptance and apply the sign correction in FIX.
REQ-018 b == 0 on a divide SHALL give dz=1, lo = all ones, hi = a (unchanged dividend), with unchanged latency.
REQ-019 DIV of the most negative value by -1 SHALL give lo = most negative value, hi = 0, dz=0.
REQ-020 start while busy SHALL be ignored; it SHALL NOT be queued.
REQ-021 wr_hi/wr_lo while busy SHALL be ignored.
REQ-022 start together with wr_hi/wr_lo in IDLE: start SHALL win and the loads SHALL be dropped.
REQ-023 wr_hi and wr_lo together SHALL load a into both HI and LO.
REQ-024 Operands SHALL be captured at acceptance; later changes to a, b or op SHALL NOT affect the operation in flight.
REQ-025 hi/lo SHALL hold their previous values until DONE; intermediate values SHALL NOT be visible on hi/lo.

Reset
REQ-026 rst SHALL force IDLE and clear busy, done, dz, hi and lo to 0.
REQ-027 rst SHALL take priority over start and the direct loads in the same cycle.
REQ-028 rst during CALC or FIX SHALL abort the operation with no done pulse.

Configuration
REQ-029 Macro SEQ_MULDIV_SIGNED_EN defined: MULT and DIV SHALL behave as signed operations per REQ-016 to REQ-019.
REQ-030 Macro absent: op[0] SHALL be ignored, all ops SHALL be unsigned, the sign-correction logic SHALL be omitted, FIX SHALL still take one cycle, and latency SHALL remain W+2.

Structure
REQ-031 Package seq_muldiv_pkg SHALL hold the op encoding enum, the state enum and the latency constant function (W+2).
REQ-032 One sub-module, seq_muldiv_addsub (W+1-bit add/subtract with carry out), SHALL be shared by the multiply and divide datapaths.

Verification (W=16)
REQ-033 Reset, then MULTU a=0xFFFF b=0xFFFF -> done at cycle 18, hi=0xFFFE, lo=0x0001, dz=0.
REQ-034 MULT a=0xFFFD (-3) b=0x0007 (SIGNED_EN defined) -> hi=0xFFFF, lo=0xFFEB.
REQ-035 DIV a=0xFFF9 (-7) b=0x0002 -> lo=0xFFFD, hi=0xFFFF; then DIV a=0x8000 b=0xFFFF -> lo=0x8000, hi=0x0000.
REQ-036 DIVU a=0x1234 b=0 -> dz=1, lo=0xFFFF, hi=0x1234, done at cycle 18.
REQ-037 start pulsed again at cycle 5 of a DIVU 100/7 -> ignored, single done, lo=14, hi=2; wr_lo a=0xABCD issued while busy -> ignored; the same wr_lo in IDLE -> lo=0xABCD.
REQ-038 rst at cycle 8 of a MULTU -> busy=0, no done pulse, hi=lo=0; the next start completes normally.
